// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO peripheral.
//   Holds DOUT/DIR/IRQ_EN/IRQ_POL registers and synchronizes pad inputs into DIN.
//   Detects edges per pin into a sticky IRQ_ST (write-1-to-clear) and raises a
//   registered level interrupt.
//   Register map (addr[4:2]): 0 DOUT, 1 DIR, 2 DIN (RO), 3 IRQ_EN, 4 IRQ_ST (W1C),
//   5 IRQ_POL (1=rise, 0=fall), 6/7 unmapped (read 0).
// Ports:
//   clk, reset_n          clock, async active-low reset
//   cs_gpio_n, we         chip select (active low), write enable
//   addr, be, write_data  byte address (addr[1:0] ignored), byte enables, write data
//   read_data_gpio        combinational read data, 0 unless selected for read
//   gpio_in               asynchronous pad inputs
//   gpio_out, gpio_oe     DOUT / DIR straight from flops
//   gpio_irq              registered level interrupt

// Per-pin input path: synchronizer, edge detect, sticky status bit.
module gpio_pin #(
   parameter int SYNC_STG = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pad,
   input  logic pol,
   input  logic arm,
   input  logic w1c,
   output logic din,
   output logic irq_st
);
   logic [SYNC_STG-1:0] sync_q;
   logic                din_d;
   logic                hit;

   assign din = sync_q[SYNC_STG-1];
   // arm stays low until the sync chain and din_d hold real pad samples,
   // so a pad that is already high at reset release is not seen as an edge.
   assign hit = arm & (pol ? (din & ~din_d) : (~din & din_d));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         din_d  <= 1'b0;
         irq_st <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STG-2:0], pad};
         din_d  <= din;
         // set wins over a same-cycle clear
         irq_st <= hit | (irq_st & ~w1c);
      end
   end
endmodule

module gpio_ctrl #(
   parameter int GPIO_W   = 16,
   parameter int SYNC_STG = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cs_gpio_n,
   input  logic              we,
   input  logic [4:0]        addr,
   input  logic [3:0]        be,
   input  logic [31:0]       write_data,
   output logic [31:0]       read_data_gpio,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic [GPIO_W-1:0] gpio_oe,
   output logic              gpio_irq
);
   localparam logic [2:0] A_DOUT = 3'd0;
   localparam logic [2:0] A_DIR  = 3'd1;
   localparam logic [2:0] A_DIN  = 3'd2;
   localparam logic [2:0] A_IEN  = 3'd3;
   localparam logic [2:0] A_IST  = 3'd4;
   localparam logic [2:0] A_POL  = 3'd5;

   typedef struct packed {
      logic       wr;
      logic       rd;
      logic [2:0] sel;
   } bus_req_t;

   bus_req_t          req;
   logic [GPIO_W-1:0] bmask;
   logic [GPIO_W-1:0] wdata;
   logic [GPIO_W-1:0] dout, dir, irq_en, irq_pol;
   logic [GPIO_W-1:0] din, irq_st, w1c;
   logic [GPIO_W-1:0] reg_sel;
   logic [SYNC_STG:0] vld_pipe;
   logic              unused_bits;

   assign unused_bits = ^{addr[1:0], write_data};

   assign req.wr  = ~cs_gpio_n & we;
   assign req.rd  = ~cs_gpio_n & ~we;
   assign req.sel = addr[4:2];
   assign wdata   = write_data[GPIO_W-1:0];
   assign w1c     = (req.wr && req.sel == A_IST) ? (wdata & bmask) : '0;

   // per-bit write mask from the byte lanes
   for (genvar i = 0; i < GPIO_W; i++) begin : g_mask
      assign bmask[i] = be[i/8];
   end

   for (genvar i = 0; i < GPIO_W; i++) begin : g_pin
      gpio_pin #(.SYNC_STG(SYNC_STG)) u_pin (
         .clk     (clk),
         .reset_n (reset_n),
         .pad     (gpio_in[i]),
         .pol     (irq_pol[i]),
         .arm     (vld_pipe[SYNC_STG]),
         .w1c     (w1c[i]),
         .din     (din[i]),
         .irq_st  (irq_st[i])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout     <= '0;
         dir      <= '0;
         irq_en   <= '0;
         irq_pol  <= '0;
         vld_pipe <= '0;
         gpio_irq <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[SYNC_STG-1:0], 1'b1};
         gpio_irq <= |(irq_st & irq_en);
         if (req.wr) begin
            case (req.sel)
               A_DOUT:  dout    <= (dout    & ~bmask) | (wdata & bmask);
               A_DIR:   dir     <= (dir     & ~bmask) | (wdata & bmask);
               A_IEN:   irq_en  <= (irq_en  & ~bmask) | (wdata & bmask);
               A_POL:   irq_pol <= (irq_pol & ~bmask) | (wdata & bmask);
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      reg_sel = '0;
      case (req.sel)
         A_DOUT:  reg_sel = dout;
         A_DIR:   reg_sel = dir;
         A_DIN:   reg_sel = din;
         A_IEN:   reg_sel = irq_en;
         A_IST:   reg_sel = irq_st;
         A_POL:   reg_sel = irq_pol;
         default: reg_sel = '0;
      endcase
      read_data_gpio = '0;
      if (req.rd) read_data_gpio[GPIO_W-1:0] = reg_sel;
   end

   assign gpio_out = dout;
   assign gpio_oe  = dir;
endmodule

// File: tb/tb_gpio_ctrl.sv
module tb_gpio_ctrl;
   logic        clk, reset_n, cs_gpio_n, we;
   logic [4:0]  addr;
   logic [3:0]  be;
   logic [31:0] write_data, read_data_gpio;
   logic [15:0] gpio_in, gpio_out, gpio_oe;
   logic        gpio_irq;
   int          pass_cnt = 0;
   int          chk_cnt  = 0;
   logic [31:0] d;

   gpio_ctrl #(.GPIO_W(16), .SYNC_STG(2)) dut (
      .clk(clk), .reset_n(reset_n), .cs_gpio_n(cs_gpio_n), .we(we), .addr(addr),
      .be(be), .write_data(write_data), .read_data_gpio(read_data_gpio),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .gpio_irq(gpio_irq)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] v, input logic [3:0] b);
      @(negedge clk);
      cs_gpio_n = 0; we = 1; addr = a; write_data = v; be = b;
      @(posedge clk); #1;
      cs_gpio_n = 1; we = 0;
   endtask

   task automatic bus_read(input logic [4:0] a, output logic [31:0] v);
      cs_gpio_n = 0; we = 0; addr = a;
      #1;
      v = read_data_gpio;
      cs_gpio_n = 1;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1;
      tick;
      for (int a = 0; a < 8; a++) begin
         bus_read(5'(a * 4), d);
         chk_cnt++; if (d !== 32'h0) $display("FAIL reset_read a=%0d got %h exp 0", a, d); else pass_cnt++;
      end
      chk_cnt++; if ({gpio_out, gpio_oe, gpio_irq} !== 33'h0) $display("FAIL reset_outs got %h/%h/%b exp 0", gpio_out, gpio_oe, gpio_irq); else pass_cnt++;
      bus_write(5'h00, 32'h0000_A5A5, 4'hF);
      bus_write(5'h04, 32'h0000_FFFF, 4'hF);
      chk_cnt++; if (gpio_out !== 16'hA5A5) $display("FAIL pre_reset_dout got %h exp a5a5", gpio_out); else pass_cnt++;
      gpio_in = 16'h0001;
      repeat (3) tick;
      #2 reset_n = 0;
      #1;
      chk_cnt++; if ({gpio_out, gpio_oe, gpio_irq} !== 33'h0) $display("FAIL midreset_outs got %h/%h/%b exp 0", gpio_out, gpio_oe, gpio_irq); else pass_cnt++;
      bus_read(5'h00, d);
      chk_cnt++; if (d !== 32'h0) $display("FAIL midreset_dout got %h exp 0", d); else pass_cnt++;
      bus_read(5'h08, d);
      chk_cnt++; if (d !== 32'h0) $display("FAIL midreset_din got %h exp 0", d); else pass_cnt++;
      @(negedge clk) reset_n = 1;
      // pad held high across release, POL rising armed at once: no edge expected
      bus_write(5'h14, 32'h1, 4'hF);
      repeat (5) tick;
      bus_read(5'h10, d);
      chk_cnt++; if (d !== 32'h0) $display("FAIL post_release_no_edge got %h exp 0", d); else pass_cnt++;
      bus_read(5'h08, d);
      chk_cnt++; if (d !== 32'h1) $display("FAIL post_release_din got %h exp 1", d); else pass_cnt++;
      gpio_in = 16'h0000;
      repeat (4) tick;
   endtask

   task automatic test_byte_writes;
      bus_write(5'h00, 32'h1234_5678, 4'b0001);
      bus_read(5'h00, d);
      chk_cnt++; if (d !== 32'h0000_0078) $display("FAIL be0001 got %h exp 00000078", d); else pass_cnt++;
      bus_write(5'h00, 32'h1234_5678, 4'b1111);
      bus_read(5'h00, d);
      chk_cnt++; if (d !== 32'h0000_5678) $display("FAIL be1111 got %h exp 00005678", d); else pass_cnt++;
      bus_write(5'h00, 32'h0000_AB00, 4'b0010);
      bus_read(5'h00, d);
      chk_cnt++; if (d !== 32'h0000_AB78) $display("FAIL be0010 got %h exp 0000ab78", d); else pass_cnt++;
      chk_cnt++; if (gpio_out !== 16'hAB78) $display("FAIL gpio_out got %h exp ab78", gpio_out); else pass_cnt++;
   endtask

   task automatic test_rising_edge;
      bus_write(5'h14, 32'h0000_FFFF, 4'hF);
      bus_write(5'h0C, 32'h0000_0001, 4'hF);
      gpio_in[0] = 1'b1;
      tick;
      bus_read(5'h08, d);
      chk_cnt++; if (d !== 32'h0) $display("FAIL din_1clk got %h exp 0", d); else pass_cnt++;
      tick;
      bus_read(5'h08, d);
      chk_cnt++; if (d !== 32'h1) $display("FAIL din_2clk got %h exp 1", d); else pass_cnt++;
      tick;
      bus_read(5'h10, d);
      chk_cnt++; if (d !== 32'h1) $display("FAIL irqst_3clk got %h exp 1", d); else pass_cnt++;
      chk_cnt++; if (gpio_irq !== 1'b0) $display("FAIL irq_3clk got %b exp 0", gpio_irq); else pass_cnt++;
      tick;
      chk_cnt++; if (gpio_irq !== 1'b1) $display("FAIL irq_4clk got %b exp 1", gpio_irq); else pass_cnt++;
      bus_write(5'h10, 32'h1, 4'hF);
      chk_cnt++; if (gpio_irq !== 1'b1) $display("FAIL irq_at_w1c got %b exp 1", gpio_irq); else pass_cnt++;
      bus_read(5'h10, d);
      chk_cnt++; if (d !== 32'h0) $display("FAIL irqst_cleared got %h exp 0", d); else pass_cnt++;
      tick;
      chk_cnt++; if (gpio_irq !== 1'b0) $display("FAIL irq_after_w1c got %b exp 0", gpio_irq); else pass_cnt++;
   endtask

   task automatic test_collision;
      bus_write(5'h14, 32'h0000_FFF7, 4'hF);
      gpio_in[3] = 1'b1;
      repeat (4) tick;
      bus_read(5'h10, d);
      chk_cnt++; if (d !== 32'h0) $display("FAIL rise_on_fallpol got %h exp 0", d); else pass_cnt++;
      gpio_in[3] = 1'b0;
      repeat (4) tick;
      bus_read(5'h10, d);
      chk_cnt++; if (d !== 32'h8) $display("FAIL fall_set got %h exp 8", d); else pass_cnt++;
      gpio_in[3] = 1'b1;
      repeat (4) tick;
      gpio_in[3] = 1'b0;
      tick;
      tick;
      bus_write(5'h10, 32'h8, 4'hF);   // commits on the edge the new hit sets
      bus_read(5'h10, d);
      chk_cnt++; if (d !== 32'h8) $display("FAIL set_beats_clear got %h exp 8", d); else pass_cnt++;
      bus_write(5'h10, 32'h8, 4'hF);
      bus_read(5'h10, d);
      chk_cnt++; if (d !== 32'h0) $display("FAIL plain_clear got %h exp 0", d); else pass_cnt++;
   endtask

   task automatic test_masked;
      gpio_in[5] = 1'b1;
      repeat (3) tick;
      bus_read(5'h10, d);
      chk_cnt++; if (d !== 32'h20) $display("FAIL masked_st got %h exp 20", d); else pass_cnt++;
      tick;
      chk_cnt++; if (gpio_irq !== 1'b0) $display("FAIL masked_irq got %b exp 0", gpio_irq); else pass_cnt++;
      bus_write(5'h0C, 32'h20, 4'hF);
      chk_cnt++; if (gpio_irq !== 1'b0) $display("FAIL en_same_clk got %b exp 0", gpio_irq); else pass_cnt++;
      tick;
      chk_cnt++; if (gpio_irq !== 1'b1) $display("FAIL en_next_clk got %b exp 1", gpio_irq); else pass_cnt++;
      bus_write(5'h0C, 32'h0, 4'hF);
      tick;
      chk_cnt++; if (gpio_irq !== 1'b0) $display("FAIL disable got %b exp 0", gpio_irq); else pass_cnt++;
   endtask

   task automatic test_pol_change;
      bus_write(5'h10, 32'h20, 4'hF);
      bus_write(5'h14, 32'h0000_FFD7, 4'hF);
      repeat (3) tick;
      bus_read(5'h10, d);
      chk_cnt++; if (d !== 32'h0) $display("FAIL pol_no_spurious got %h exp 0", d); else pass_cnt++;
      gpio_in[5] = 1'b0;
      repeat (3) tick;
      bus_read(5'h10, d);
      chk_cnt++; if (d !== 32'h20) $display("FAIL pol_new_fall got %h exp 20", d); else pass_cnt++;
   endtask

   task automatic test_bus_gating;
      @(negedge clk);
      cs_gpio_n = 1; we = 1; addr = 5'h00; write_data = 32'hFFFF_FFFF; be = 4'hF;
      #1;
      chk_cnt++; if (read_data_gpio !== 32'h0) $display("FAIL rd_when_deselected got %h exp 0", read_data_gpio); else pass_cnt++;
      tick;
      we = 0;
      bus_read(5'h00, d);
      chk_cnt++; if (d !== 32'h0000_AB78) $display("FAIL deselected_write got %h exp ab78", d); else pass_cnt++;
      @(negedge clk);
      cs_gpio_n = 0; we = 1; addr = 5'h04; write_data = 32'h0; be = 4'hF;
      #1;
      chk_cnt++; if (read_data_gpio !== 32'h0) $display("FAIL rd_during_write got %h exp 0", read_data_gpio); else pass_cnt++;
      @(posedge clk); #1;
      cs_gpio_n = 1; we = 0;
      bus_read(5'h18, d);
      chk_cnt++; if (d !== 32'h0) $display("FAIL unmapped_18 got %h exp 0", d); else pass_cnt++;
      bus_write(5'h1C, 32'hFFFF_FFFF, 4'hF);
      bus_read(5'h1C, d);
      chk_cnt++; if (d !== 32'h0) $display("FAIL unmapped_1c got %h exp 0", d); else pass_cnt++;
      bus_write(5'h08, 32'h0000_FFFF, 4'hF);
      bus_read(5'h08, d);
      chk_cnt++; if (d !== 32'h1) $display("FAIL din_write_ignored got %h exp 1", d); else pass_cnt++;
      bus_write(5'h04, 32'h0000_FFFF, 4'hF);
      bus_write(5'h00, 32'h0000_0000, 4'hF);
      repeat (3) tick;
      bus_read(5'h08, d);
      chk_cnt++; if (d !== 32'h1) $display("FAIL no_loopback got %h exp 1", d); else pass_cnt++;
      chk_cnt++; if (gpio_oe !== 16'hFFFF) $display("FAIL gpio_oe got %h exp ffff", gpio_oe); else pass_cnt++;
      bus_write(5'h00, 32'hFFFF_FFFF, 4'hF);
      bus_read(5'h00, d);
      chk_cnt++; if (d !== 32'h0000_FFFF) $display("FAIL upper_bits got %h exp 0000ffff", d); else pass_cnt++;
   endtask

   initial begin
      reset_n = 0; cs_gpio_n = 1; we = 0; addr = '0; be = '0;
      write_data = '0; gpio_in = '0;
      test_reset;
      test_byte_writes;
      test_rising_edge;
      test_collision;
      test_masked;
      test_pol_change;
      test_bus_gating;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
